// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl: program counter and call/return sequencer for a PIC10F200-class core.
// Owns the 9-bit PC, drives the 2-level LIFO stack strobes (load/inc/dec), reads the
// top of stack back on return, and tracks stack depth with sticky overflow/underflow flags.
// Optional build macro STACK_GUARD_EN: blocks stack strobes on overflow/underflow and
// returns to RESET_VEC on an empty-stack RETLW. When it is not defined, pushes and pops
// wrap as the silicon does.
module pc_stack_ctrl #(
  parameter logic [8:0] RESET_VEC   = 9'h1FF,
  parameter int         STACK_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic [8:0] target,
  output logic       cmd_ready,
  output logic [8:0] pc,
  output logic [8:0] pc_out,
  output logic       stack_load,
  output logic       stack_inc,
  output logic       stack_dec,
  input  logic [8:0] stack_bus,
  output logic [1:0] depth,
  output logic       stk_ovf,
  output logic       stk_unf
);

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_INC   = 3'd1;
  localparam logic [2:0] CMD_SKIP  = 3'd2;
  localparam logic [2:0] CMD_GOTO  = 3'd3;
  localparam logic [2:0] CMD_CALL  = 3'd4;
  localparam logic [2:0] CMD_RETLW = 3'd5;
  localparam logic [2:0] CMD_LDPCL = 3'd6;

  localparam logic [1:0] DEPTH_FULL = 2'(STACK_DEPTH);

`ifdef STACK_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_LD  = 3'd1,
    S_PUSH_INC = 3'd2,
    S_POP_DEC  = 3'd3,
    S_POP_RD   = 3'd4
  } state_t;

  state_t     r_state;
  logic [8:0] r_pc;
  logic [8:0] r_pc_out;
  logic [8:0] r_tgt;
  logic       r_cmd_ready;
  logic       r_stack_load;
  logic       r_stack_inc;
  logic       r_stack_dec;
  logic [1:0] r_depth;
  logic       r_stk_ovf;
  logic       r_stk_unf;
  logic       r_pop_unf;   // the RETLW in flight started on an empty stack

  logic w_accept;
  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_accept  = cmd_valid && r_cmd_ready;
  assign w_full    = (r_depth == DEPTH_FULL);
  assign w_empty   = (r_depth == 2'd0);
  // Guarded build withholds strobes that would corrupt the stack; unguarded always strobes.
  assign w_push_ok = !(GUARD && w_full);
  assign w_pop_ok  = !(GUARD && w_empty);

  // Sequencer FSM: PC update, stack strobes (registered Moore outputs) and depth/flag tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_VEC;
      r_pc_out     <= 9'h000;
      r_tgt        <= 9'h000;
      r_cmd_ready  <= 1'b1;
      r_stack_load <= 1'b0;
      r_stack_inc  <= 1'b0;
      r_stack_dec  <= 1'b0;
      r_depth      <= 2'd0;
      r_stk_ovf    <= 1'b0;
      r_stk_unf    <= 1'b0;
      r_pop_unf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (cmd)
              CMD_NOP:   r_pc <= r_pc;
              CMD_INC:   r_pc <= r_pc + 9'd1;
              CMD_SKIP:  r_pc <= r_pc + 9'd2;
              CMD_GOTO:  r_pc <= target;
              CMD_LDPCL: r_pc <= {1'b0, target[7:0]};
              CMD_CALL: begin
                // pc_out is the return address; it stays put until the next CALL.
                r_pc_out     <= r_pc + 9'd1;
                r_tgt        <= {1'b0, target[7:0]};
                r_stack_load <= w_push_ok;
                r_cmd_ready  <= 1'b0;
                r_state      <= S_PUSH_LD;
              end
              CMD_RETLW: begin
                r_stack_dec <= w_pop_ok;
                r_pop_unf   <= w_empty;
                r_cmd_ready <= 1'b0;
                r_state     <= S_POP_DEC;
              end
              default:   r_pc <= r_pc + 9'd1;  // reserved opcode acts as INC
            endcase
          end else begin
            r_pc <= r_pc;
          end
        end
        S_PUSH_LD: begin
          r_stack_load <= 1'b0;
          r_stack_inc  <= w_push_ok;
          r_state      <= S_PUSH_INC;
        end
        S_PUSH_INC: begin
          r_stack_inc <= 1'b0;
          r_pc        <= r_tgt;
          if (w_full) begin
            r_stk_ovf <= 1'b1;
          end else begin
            r_depth <= r_depth + 2'd1;
          end
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_POP_DEC: begin
          r_stack_dec <= 1'b0;
          if (w_empty) begin
            r_stk_unf <= 1'b1;
          end else begin
            r_depth <= r_depth - 2'd1;
          end
          r_state <= S_POP_RD;
        end
        S_POP_RD: begin
          // Stack pointer settled during POP_DEC, so stack_bus now holds the return address.
          if (GUARD && r_pop_unf) begin
            r_pc <= RESET_VEC;
          end else begin
            r_pc <= stack_bus;
          end
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_stack_load <= 1'b0;
          r_stack_inc  <= 1'b0;
          r_stack_dec  <= 1'b0;
          r_cmd_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign pc         = r_pc;
  assign pc_out     = r_pc_out;
  assign stack_load = r_stack_load;
  assign stack_inc  = r_stack_inc;
  assign stack_dec  = r_stack_dec;
  assign depth      = r_depth;
  assign stk_ovf    = r_stk_ovf;
  assign stk_unf    = r_stk_unf;

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Self-checking bench for pc_stack_ctrl: table of single-cycle commands followed by
// hand-written CALL/RETLW, overflow/underflow and mid-sequence reset scenarios.
module tb_pc_stack_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [8:0] target;
  logic       cmd_ready;
  logic [8:0] pc;
  logic [8:0] pc_out;
  logic       stack_load;
  logic       stack_inc;
  logic       stack_dec;
  logic [8:0] stack_bus;
  logic [1:0] depth;
  logic       stk_ovf;
  logic       stk_unf;

  int n_checks;
  int n_errors;

`ifdef STACK_GUARD_EN
  localparam logic GUARDED = 1'b1;
`else
  localparam logic GUARDED = 1'b0;
`endif

  pc_stack_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .target     (target),
    .cmd_ready  (cmd_ready),
    .pc         (pc),
    .pc_out     (pc_out),
    .stack_load (stack_load),
    .stack_inc  (stack_inc),
    .stack_dec  (stack_dec),
    .stack_bus  (stack_bus),
    .depth      (depth),
    .stk_ovf    (stk_ovf),
    .stk_unf    (stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [2:0] cmd;
    logic [8:0] target;
    logic [8:0] exp_pc;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [8:0] t);
    cmd_valid = 1'b1;
    cmd       = c;
    target    = t;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_call(input logic [8:0] t, input logic [8:0] exp_ret, input logic exp_strobe,
                         input logic [8:0] exp_pc, input logic [1:0] exp_depth, input logic exp_ovf);
    issue(3'd4, t);
    check("call_ld_strobe", {8'h00, stack_load}, {8'h00, exp_strobe});
    if (exp_strobe) check("call_ret_addr", pc_out, exp_ret);
    check("call_ld_inc0", {8'h00, stack_inc}, 9'h000);
    check("call_ld_ready", {8'h00, cmd_ready}, 9'h000);
    tick();
    check("call_inc_strobe", {8'h00, stack_inc}, {8'h00, exp_strobe});
    check("call_inc_load0", {8'h00, stack_load}, 9'h000);
    check("call_inc_ready", {8'h00, cmd_ready}, 9'h000);
    tick();
    check("call_pc", pc, exp_pc);
    check("call_depth", {7'h00, depth}, {7'h00, exp_depth});
    check("call_ovf", {8'h00, stk_ovf}, {8'h00, exp_ovf});
    check("call_ready", {8'h00, cmd_ready}, 9'h001);
    check("call_inc_end", {8'h00, stack_inc}, 9'h000);
  endtask

  task automatic do_ret(input logic [8:0] bus, input logic exp_dec, input logic [8:0] exp_pc,
                        input logic [1:0] exp_depth, input logic exp_unf);
    stack_bus = bus;
    issue(3'd5, 9'h000);
    check("ret_dec_strobe", {8'h00, stack_dec}, {8'h00, exp_dec});
    check("ret_dec_ready", {8'h00, cmd_ready}, 9'h000);
    tick();
    check("ret_rd_dec0", {8'h00, stack_dec}, 9'h000);
    check("ret_rd_depth", {7'h00, depth}, {7'h00, exp_depth});
    check("ret_rd_unf", {8'h00, stk_unf}, {8'h00, exp_unf});
    tick();
    check("ret_pc", pc, exp_pc);
    check("ret_ready", {8'h00, cmd_ready}, 9'h001);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    target    = 9'h000;
    stack_bus = 9'h000;

    vecs[0]  = '{1'b1, 3'd1, 9'h000, 9'h000};  // INC wraps 1FF -> 000
    vecs[1]  = '{1'b1, 3'd1, 9'h000, 9'h001};
    vecs[2]  = '{1'b1, 3'd2, 9'h000, 9'h003};  // SKIP
    vecs[3]  = '{1'b1, 3'd0, 9'h1AB, 9'h003};  // NOP
    vecs[4]  = '{1'b1, 3'd3, 9'h1F0, 9'h1F0};  // GOTO keeps bit 8
    vecs[5]  = '{1'b0, 3'd3, 9'h123, 9'h1F0};  // no valid -> ignored
    vecs[6]  = '{1'b1, 3'd3, 9'h1FE, 9'h1FE};
    vecs[7]  = '{1'b1, 3'd2, 9'h000, 9'h000};  // SKIP wraps 1FE -> 000
    vecs[8]  = '{1'b1, 3'd6, 9'h1C7, 9'h0C7};  // LDPCL clears bit 8
    vecs[9]  = '{1'b1, 3'd7, 9'h155, 9'h0C8};  // reserved acts as INC
    vecs[10] = '{1'b1, 3'd3, 9'h1FF, 9'h1FF};
    vecs[11] = '{1'b1, 3'd3, 9'h010, 9'h010};

    // Reset values while held in reset.
    #12;
    check("rst_pc", pc, 9'h1FF);
    check("rst_pc_out", pc_out, 9'h000);
    check("rst_depth", {7'h00, depth}, 9'h000);
    check("rst_ready", {8'h00, cmd_ready}, 9'h001);
    check("rst_strobes", {6'h00, stack_load, stack_inc, stack_dec}, 9'h000);
    check("rst_flags", {7'h00, stk_ovf, stk_unf}, 9'h000);
    tick();
    rst = 1'b1;
    tick();
    check("rel_pc", pc, 9'h1FF);

    // Single-cycle commands.
    for (int i = 0; i < 12; i++) begin
      cmd_valid = vecs[i].valid;
      cmd       = vecs[i].cmd;
      target    = vecs[i].target;
      tick();
      cmd_valid = 1'b0;
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_ready", i), {8'h00, cmd_ready}, 9'h001);
    end

    // CALL from 010 to 1A5 then return.
    do_call(9'h1A5, 9'h011, 1'b1, 9'h0A5, 2'd1, 1'b0);
    do_ret(9'h011, 1'b1, 9'h011, 2'd0, 1'b0);

    // Three nested calls: the third overflows.
    issue(3'd3, 9'h000);
    check("goto0_pc", pc, 9'h000);
    do_call(9'h020, 9'h001, 1'b1, 9'h020, 2'd1, 1'b0);
    do_call(9'h040, 9'h021, 1'b1, 9'h040, 2'd2, 1'b0);
    do_call(9'h060, 9'h041, !GUARDED, 9'h060, 2'd2, 1'b1);

    // Unwind, then pop an empty stack.
    do_ret(9'h041, 1'b1, 9'h041, 2'd1, 1'b0);
    do_ret(9'h021, 1'b1, 9'h021, 2'd0, 1'b0);
    do_ret(9'h155, !GUARDED, GUARDED ? 9'h1FF : 9'h155, 2'd0, 1'b1);
    check("ovf_sticky", {8'h00, stk_ovf}, 9'h001);

    // Reset during PUSH_LD aborts the sequence.
    issue(3'd4, 9'h0AA);
    check("abort_ld", {8'h00, stack_load}, 9'h001);
    #2;
    rst = 1'b0;
    #1;
    check("abort_strobes", {6'h00, stack_load, stack_inc, stack_dec}, 9'h000);
    check("abort_pc", pc, 9'h1FF);
    check("abort_ready", {8'h00, cmd_ready}, 9'h001);
    check("abort_flags", {7'h00, stk_ovf, stk_unf}, 9'h000);
    check("abort_pc_out", pc_out, 9'h000);
    tick();
    rst = 1'b1;
    tick();
    check("post_strobes", {6'h00, stack_load, stack_inc, stack_dec}, 9'h000);
    tick();
    check("post_strobes2", {6'h00, stack_load, stack_inc, stack_dec}, 9'h000);
    check("post_pc", pc, 9'h1FF);

    // GOTO held valid during the CALL sequence is ignored.
    issue(3'd4, 9'h1A5);
    check("busy_ret", pc_out, 9'h000);
    cmd_valid = 1'b1;
    cmd       = 3'd3;
    target    = 9'h123;
    tick();
    check("busy_inc", {8'h00, stack_inc}, 9'h001);
    check("busy_pc", pc, 9'h1FF);
    tick();
    cmd_valid = 1'b0;
    check("busy_final_pc", pc, 9'h0A5);
    check("busy_depth", {7'h00, depth}, 9'h001);
    tick();
    check("busy_idle_pc", pc, 9'h0A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
